// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and widths for the PLL reset sequencer.
// FSM state encoding plus qualification/hold counter and loss counter widths.
package pll_reset_sequencer_pkg;

   typedef enum logic [1:0] {
      StWaitLock,
      StQualify,
      StHold,
      StRun
   } state_e;

   localparam int unsigned CntWidth  = 16;
   localparam int unsigned LossWidth = 8;

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Generic two-flop synchronizer with synchronous active-low clear.
module pll_reset_sequencer_sync2 #(
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             clr_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, holds the PLL-domain reset, then releases it; drops it on lock loss.
// Optional loss statistics are built only when PLL_LOSS_STATS_EN is defined.
module pll_reset_sequencer
   import pll_reset_sequencer_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = 1024,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic                 clock_i,
   input  logic                 reset_ni,
   input  logic                 locked_i,
   input  logic                 clear_loss_i,
   output logic                 sys_reset_n_o,
   output logic                 ready_o,
   output logic [LossWidth-1:0] loss_count_o,
   output logic                 loss_sticky_o
);

   localparam logic [CntWidth-1:0] LockLast = CntWidth'(LOCK_CYCLES - 1);
   localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HOLD_CYCLES - 1);

   logic                lock_s;
   state_e              state_q, state_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                run_q;

   pll_reset_sequencer_sync2 #(
      .Width(1)
   ) u_lock_sync (
      .clk_i  (clock_i),
      .clr_ni (reset_ni),
      .d_i    (locked_i),
      .q_o    (lock_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StWaitLock: begin
            cnt_d = '0;
            // The cycle that first sees lock_s counts as the first qualifying cycle.
            if (lock_s) begin
               state_d = StQualify;
               cnt_d   = CntWidth'(1);
            end
         end
         StQualify: begin
            if (!lock_s) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (cnt_q == LockLast) begin
               state_d = StHold;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StHold: begin
            if (!lock_s) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (cnt_q == HoldLast) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRun: begin
            if (!lock_s) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         state_q <= StWaitLock;
         cnt_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= (state_d == StRun);
      end
   end

   assign sys_reset_n_o = run_q;
   assign ready_o       = run_q;

`ifdef PLL_LOSS_STATS_EN
   localparam logic [LossWidth-1:0] LossMax = {LossWidth{1'b1}};

   logic                 loss;
   logic [LossWidth-1:0] loss_cnt_q;
   logic                 loss_sticky_q;

   assign loss = (state_q == StRun) && !lock_s;

   // A loss coinciding with a clear wins: the count restarts at one.
   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         loss_cnt_q    <= '0;
         loss_sticky_q <= 1'b0;
      end else if (loss) begin
         loss_cnt_q    <= clear_loss_i ? LossWidth'(1) :
                          (loss_cnt_q == LossMax) ? loss_cnt_q : loss_cnt_q + 1'b1;
         loss_sticky_q <= 1'b1;
      end else if (clear_loss_i) begin
         loss_cnt_q    <= '0;
         loss_sticky_q <= 1'b0;
      end
   end

   assign loss_count_o  = loss_cnt_q;
   assign loss_sticky_o = loss_sticky_q;
`else
   logic unused_clear_loss;
   assign unused_clear_loss = clear_loss_i;
   assign loss_count_o      = '0;
   assign loss_sticky_o     = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer (LOCK_CYCLES=8, HOLD_CYCLES=4).
// Expectations come from a run-length model of the synchronized lock signal.
module tb_pll_reset_sequencer;

   localparam int unsigned L = 8;
   localparam int unsigned H = 4;
`ifdef PLL_LOSS_STATS_EN
   localparam bit Stats = 1'b1;
`else
   localparam bit Stats = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_ni = 1'b0;
   logic       locked_i = 1'b0;
   logic       clear_loss_i = 1'b0;
   logic       sys_reset_n_o;
   logic       ready_o;
   logic [7:0] loss_count_o;
   logic       loss_sticky_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_s1 = 0, m_s2 = 0, m_ready = 0, m_sticky = 0;
   int m_run = 0;
   int m_cnt = 0;

   pll_reset_sequencer #(
      .LOCK_CYCLES(L),
      .HOLD_CYCLES(H)
   ) dut (
      .clock_i       (clk),
      .reset_ni      (reset_ni),
      .locked_i      (locked_i),
      .clear_loss_i  (clear_loss_i),
      .sys_reset_n_o (sys_reset_n_o),
      .ready_o       (ready_o),
      .loss_count_o  (loss_count_o),
      .loss_sticky_o (loss_sticky_o)
   );

   always #5 clk = ~clk;

   // One clock edge; the model sees the same inputs the DUT samples, then outputs settle.
   task automatic step();
      bit loss;
      @(posedge clk);
      if (!reset_ni) begin
         m_s1 = 0; m_s2 = 0; m_run = 0; m_ready = 0; m_cnt = 0; m_sticky = 0;
      end else begin
         loss    = m_ready && !m_s2;
         m_run   = m_s2 ? ((m_run < 100000) ? m_run + 1 : m_run) : 0;
         m_ready = (m_run >= int'(L + H));
         if (Stats) begin
            if (loss) begin
               m_cnt    = clear_loss_i ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
               m_sticky = 1;
            end else if (clear_loss_i) begin
               m_cnt    = 0;
               m_sticky = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = locked_i;
      end
      #1;
   endtask

   task automatic test_reset();
      reset_ni = 1'b0;
      locked_i = 1'b1;
      step();
      step();
      checks++;
      if (sys_reset_n_o !== 1'b0) begin
         errors++; $display("FAIL reset_sys_reset_n got %b want 0", sys_reset_n_o);
      end
      checks++;
      if (ready_o !== 1'b0) begin
         errors++; $display("FAIL reset_ready got %b want 0", ready_o);
      end
      checks++;
      if (loss_count_o !== 8'd0) begin
         errors++; $display("FAIL reset_loss_count got %0d want 0", loss_count_o);
      end
      checks++;
      if (loss_sticky_o !== 1'b0) begin
         errors++; $display("FAIL reset_loss_sticky got %b want 0", loss_sticky_o);
      end
   endtask

   task automatic test_steady_lock();
      int n;
      int drops;
      reset_ni = 1'b0;
      locked_i = 1'b1;
      step();
      reset_ni = 1'b1;
      n = 0;
      while (ready_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n != 14) begin
         errors++; $display("FAIL steady_release_cycles got %0d want 14", n);
      end
      checks++;
      if (sys_reset_n_o !== 1'b1) begin
         errors++; $display("FAIL steady_sys_reset_n got %b want 1", sys_reset_n_o);
      end
      drops = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ready_o !== 1'b1 || sys_reset_n_o !== 1'b1) drops++;
      end
      checks++;
      if (drops != 0) begin
         errors++; $display("FAIL steady_hold_high got %0d drops want 0", drops);
      end
   endtask

   task automatic test_glitch();
      int n;
      reset_ni = 1'b0;
      locked_i = 1'b0;
      step();
      reset_ni = 1'b1;
      locked_i = 1'b1;
      repeat (5) step();
      locked_i = 1'b0;
      step();
      locked_i = 1'b1;
      n = 0;
      while (ready_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n != 14) begin
         errors++; $display("FAIL glitch_release_cycles got %0d want 14", n);
      end
   endtask

   task automatic test_loss();
      int n;
      int fell;
      reset_ni = 1'b0;
      locked_i = 1'b1;
      step();
      reset_ni = 1'b1;
      n = 0;
      while (ready_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n != 14) begin
         errors++; $display("FAIL loss_initial_release got %0d want 14", n);
      end
      locked_i = 1'b0;
      fell = 0;
      for (int k = 1; k <= 3; k++) begin
         step();
         if (fell == 0 && sys_reset_n_o === 1'b0) fell = k;
      end
      checks++;
      if (fell != 3) begin
         errors++; $display("FAIL loss_drop_cycle got %0d want 3", fell);
      end
      checks++;
      if (ready_o !== 1'b0) begin
         errors++; $display("FAIL loss_ready got %b want 0", ready_o);
      end
      checks++;
      if (loss_count_o !== (Stats ? 8'd1 : 8'd0)) begin
         errors++; $display("FAIL loss_count got %0d want %0d", loss_count_o, Stats ? 1 : 0);
      end
      checks++;
      if (loss_sticky_o !== Stats) begin
         errors++; $display("FAIL loss_sticky got %b want %b", loss_sticky_o, Stats);
      end
      locked_i = 1'b1;
      n = 0;
      while (ready_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n != 14) begin
         errors++; $display("FAIL loss_rerelease got %0d want 14", n);
      end
   endtask

   task automatic test_saturation();
      int n;
      int timeouts;
      timeouts = 0;
      for (int i = 0; i < 300; i++) begin
         locked_i = 1'b0;
         step();
         locked_i = 1'b1;
         n = 0;
         while (ready_o !== 1'b1 && n < 40) begin
            step();
            n++;
         end
         if (n >= 40) timeouts++;
      end
      checks++;
      if (timeouts != 0) begin
         errors++; $display("FAIL sat_requalify_timeouts got %0d want 0", timeouts);
      end
      checks++;
      if (loss_count_o !== (Stats ? 8'd255 : 8'd0)) begin
         errors++; $display("FAIL sat_count got %0d want %0d", loss_count_o, Stats ? 255 : 0);
      end
      checks++;
      if (loss_sticky_o !== Stats) begin
         errors++; $display("FAIL sat_sticky got %b want %b", loss_sticky_o, Stats);
      end
      // Clear lands on the same edge the loss is registered.
      locked_i = 1'b0;
      step();
      step();
      clear_loss_i = 1'b1;
      step();
      clear_loss_i = 1'b0;
      checks++;
      if (loss_count_o !== (Stats ? 8'd1 : 8'd0)) begin
         errors++; $display("FAIL clear_vs_loss_count got %0d want %0d", loss_count_o, Stats ? 1 : 0);
      end
      checks++;
      if (loss_sticky_o !== Stats) begin
         errors++; $display("FAIL clear_vs_loss_sticky got %b want %b", loss_sticky_o, Stats);
      end
      locked_i = 1'b1;
      n = 0;
      while (ready_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      clear_loss_i = 1'b1;
      step();
      clear_loss_i = 1'b0;
      checks++;
      if (loss_count_o !== 8'd0 || loss_sticky_o !== 1'b0) begin
         errors++;
         $display("FAIL clear_only got count %0d sticky %b want 0 0", loss_count_o, loss_sticky_o);
      end
   endtask

   task automatic test_reset_in_run();
      int n;
      reset_ni = 1'b0;
      locked_i = 1'b1;
      step();
      reset_ni = 1'b1;
      n = 0;
      while (ready_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      reset_ni = 1'b0;
      step();
      reset_ni = 1'b1;
      checks++;
      if (sys_reset_n_o !== 1'b0 || ready_o !== 1'b0) begin
         errors++;
         $display("FAIL run_reset_outputs got %b %b want 0 0", sys_reset_n_o, ready_o);
      end
      checks++;
      if (loss_count_o !== 8'd0 || loss_sticky_o !== 1'b0) begin
         errors++;
         $display("FAIL run_reset_stats got %0d %b want 0 0", loss_count_o, loss_sticky_o);
      end
      n = 0;
      while (ready_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n != 14) begin
         errors++; $display("FAIL run_reset_requalify got %0d want 14", n);
      end
   endtask

   task automatic test_random();
      int seg;
      seg = 0;
      for (int i = 0; i < 3000; i++) begin
         if (seg == 0) begin
            locked_i = 1'($urandom_range(0, 1));
            seg = locked_i ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 4));
         end
         seg--;
         clear_loss_i = ($urandom_range(0, 15) == 0);
         reset_ni     = ($urandom_range(0, 299) != 0);
         step();
         checks++;
         if (ready_o !== m_ready || sys_reset_n_o !== m_ready ||
             loss_count_o !== 8'(m_cnt) || loss_sticky_o !== m_sticky) begin
            errors++;
            $display("FAIL random_cycle %0d got rdy %b srn %b cnt %0d stk %b want %b %b %0d %b",
                     i, ready_o, sys_reset_n_o, loss_count_o, loss_sticky_o,
                     m_ready, m_ready, m_cnt, m_sticky);
         end
      end
      reset_ni     = 1'b1;
      clear_loss_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_steady_lock();
      test_glitch();
      test_loss();
      test_saturation();
      test_reset_in_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter LOCK_CYCLES, default 1024: consecutive synchronized-high cycles of locked required to qualify lock (valid range 2..65535).
REQ-002 Parameter HOLD_CYCLES, default 16: cycles sys_reset_n stays low after lock qualifies (valid range 1..255).
REQ-003 Port clock, input, 1: free-running board reference clock (12 MHz), the single clock; all logic is on its rising edge.
REQ-004 Port reset_n, input, 1: synchronous, active-low reset.
REQ-005 Port locked, input, 1: PLL lock indication, asynchronous to clock.
REQ-006 Port clear_loss, input, 1: single-cycle pulse clearing loss statistics.
REQ-007 Port sys_reset_n, output, 1: active-low reset for the PLL-clocked domain, registered.
REQ-008 Port ready, output, 1: high only in state RUN, registered.
REQ-009 Port loss_count, output, 8: number of lock losses seen in RUN, saturating.
REQ-010 Port loss_sticky, output, 1: set on any lock loss in RUN, held until cleared.

Function
REQ-011 locked SHALL pass through a 2-flop synchronizer; lock_s denotes the second flop output, and all decisions use lock_s only.
REQ-012 FSM states SHALL be WAIT_LOCK, QUALIFY, HOLD, RUN.
REQ-013 WAIT_LOCK: the counter is cleared; on lock_s=1 go to QUALIFY.
REQ-014 QUALIFY: the counter increments each cycle lock_s=1; any lock_s=0 returns to WAIT_LOCK with the counter cleared; when the counter reaches LOCK_CYCLES-1 with lock_s=1, go to HOLD with the counter cleared.
REQ-015 HOLD: the counter increments; lock_s=0 returns to WAIT_LOCK; at count HOLD_CYCLES-1, go to RUN.
REQ-016 RUN: lock_s=0 SHALL go to WAIT_LOCK on the next edge.
REQ-017 sys_reset_n and ready SHALL be registered decodes of the next state and SHALL be 1 only while the state is RUN; sys_reset_n deasserts LOCK_CYCLES+HOLD_CYCLES cycles after the first cycle with lock_s=1.
REQ-018 Loss of lock in RUN SHALL drive sys_reset_n low on the clock edge that leaves RUN; there is no deassertion glitch.
REQ-019 The counter SHALL be 16 bits and never wrap; compares are exact equality.
REQ-020 A lock_s glitch of even one low cycle in QUALIFY or HOLD SHALL restart qualification from zero.

Reset
REQ-021 reset_n=0 sampled on an edge: state WAIT_LOCK, counter 0, synchronizer flops 0, sys_reset_n 0, ready 0, loss_count 0, loss_sticky 0.
REQ-022 reset_n asserted mid-operation, including in RUN, SHALL take effect on that edge and SHALL NOT count as a lock loss.

Configuration
REQ-023 Macro PLL_LOSS_STATS_EN: when defined, loss_count increments by 1 (saturating at 255) and loss_sticky sets on each RUN->WAIT_LOCK transition.
REQ-024 With PLL_LOSS_STATS_EN defined, clear_loss=1 zeroes both outputs; simultaneous clear and loss yields loss_count=1 and loss_sticky=1 (loss wins).
REQ-025 Without PLL_LOSS_STATS_EN, loss_count is tied 0, loss_sticky is tied 0, clear_loss is ignored, and no statistics flops exist.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (2 bits), the counter width constant (16), and the loss counter width constant (8).
REQ-027 One sub-module, sync2 (a generic 2-flop synchronizer with synchronous active-low clear), SHALL be instantiated for locked; the FSM, counter and statistics stay in the top.

Verification
Bench parameters: LOCK_CYCLES=8, HOLD_CYCLES=4.
REQ-028 locked steady high from cycle 0 after reset -> sys_reset_n and ready rise exactly 2+12 cycles after locked (2 synchronizer cycles + 8 + 4), then stay high.
REQ-029 locked high 5 cycles, low 1 cycle, then high -> qualification restarts; release occurs 12 cycles after the final rising lock_s.
REQ-030 In RUN, drop locked for 3 cycles -> sys_reset_n low within 3 cycles of locked falling; loss_count=1, loss_sticky=1 (macro on); re-release 12 cycles after lock_s returns.
REQ-031 Generate 300 losses in RUN (macro on) -> loss_count saturates at 255; clear_loss pulse in the same cycle as a loss -> loss_count=1.
REQ-032 Assert reset_n=0 for 1 cycle while in RUN -> all outputs 0 on that edge, loss_count unchanged from 0, re-qualification takes the full 12 cycles.
REQ-033 Build without PLL_LOSS_STATS_EN and repeat REQ-030 -> identical sys_reset_n/ready timing, loss_count=0, loss_sticky=0.
